// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Ports: clock/reset (sync, high), flush, in_* upstream, out_* downstream,
// stall_cnt/bubble_cnt saturating statistics.
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // State bits are {skid_v, main_v}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;

    logic accept;
    logic emit;
    logic load_main;
    logic load_skid;
    logic promote;
    logic stall_hit;
    logic bubble_hit;

    assign main_v    = state[0];
    assign skid_v    = state[1];
    assign out_valid = main_v;
    assign out_data  = main_d;
    // Registered ready: no path from out_ready back upstream.
    assign in_ready  = !skid_v;

    assign accept     = in_valid & in_ready;
    assign emit       = out_valid & out_ready;
    assign stall_hit  = out_valid & !out_ready;
    assign bubble_hit = !out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        promote   = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = BUSY;
                    load_main = 1'b1;
                end
            end
            BUSY: begin
                if (emit && accept) begin
                    load_main = 1'b1;
                end else if (emit) begin
                    state_nxt = EMPTY;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end
            end
            FULL: begin
                if (emit) begin
                    state_nxt = BUSY;
                    promote   = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        // Flush drops held entries and the beat offered this cycle.
        if (flush) begin
            state_nxt = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            promote   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Payload registers are never cleared; only valid bits matter.
    always_ff @(posedge clock) begin
        if (load_main) begin
            main_d <= in_data;
        end else if (promote) begin
            main_d <= skid_d;
        end
        if (load_skid) begin
            skid_d <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_hit && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bubble_hit && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule
